writeback_unit: RTL and testbench

MEM/WB pipeline register and writeback sequencer for the ARM core. It owns the register file's single write port: it selects the load or ALU result, splits instructions that need two register writes (load/store with base writeback) into two write-port cycles, and stalls upstream while doing so. Writes that target R15 go to the fetch stage as a PC load, because the register file holds only R0–R14.

---
 rtl/writeback_unit_pkg.sv | 24 ++
 rtl/wb_result_mux.sv | 36 +++
 rtl/writeback_unit.sv | 89 ++++++++
 tb/tb_writeback_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the MEM/WB writeback stage: datapath widths,
// the PC register index, the sequencer state encoding and the slot layout.
package writeback_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam logic [ADDR_WIDTH-1:0] PC_REG = ADDR_WIDTH'(15);

  typedef enum logic [0:0] {
    PRIM = 1'b0,
    BASE = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  p_en;
    logic [ADDR_WIDTH-1:0] p_dest;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  b_en;
    logic [ADDR_WIDTH-1:0] b_dest;
    logic [DATA_WIDTH-1:0] b_data;
  } wb_slot_t;

endpackage

// File: rtl/wb_result_mux.sv
// Combinational result selection: picks the load or ALU value for the slot,
// and picks the primary or base write for the register file port by phase.
module wb_result_mux
  import writeback_unit_pkg::*;
(
  input  logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] sel_data,
  input  logic                  base_phase,
  input  logic                  valid,
  input  logic                  p_en,
  input  logic [ADDR_WIDTH-1:0] p_dest,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic [ADDR_WIDTH-1:0] b_dest,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  cur_en,
  output logic [ADDR_WIDTH-1:0] cur_dest,
  output logic [DATA_WIDTH-1:0] cur_data
);

  assign sel_data = mem_read ? mem_data : alu_result;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cur_en   = valid & p_en;
    cur_dest = p_dest;
    cur_data = p_data;
    if (base_phase) begin
      cur_en   = 1'b1;
      cur_dest = b_dest;
      cur_data = b_data;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB pipeline register and writeback sequencer. Splits base-writeback
// instructions into two write-port cycles and diverts R15 writes to fetch.
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memValid,
  input  logic                  memWbEn,
  input  logic                  memMemRead,
  input  logic [ADDR_WIDTH-1:0] memDest,
  input  logic [DATA_WIDTH-1:0] memAluResult,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic                  memBaseWbEn,
  input  logic [ADDR_WIDTH-1:0] memBaseDest,
  input  logic [DATA_WIDTH-1:0] memBaseValue,
  output logic [ADDR_WIDTH-1:0] destWB,
  output logic [DATA_WIDTH-1:0] resultWB,
  output logic                  writeBackEn,
  output logic                  pcLoad,
  output logic [DATA_WIDTH-1:0] pcValue,
  output logic                  stall
);

  wb_state_t             state;
  wb_slot_t              slot;
  wb_slot_t              next_slot;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  cur_en;
  logic [ADDR_WIDTH-1:0] cur_dest;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [ADDR_WIDTH-1:0] last_dest;
  logic [DATA_WIDTH-1:0] last_data;

  wb_result_mux u_mux (
    .mem_read   (memMemRead),
    .mem_data   (memData),
    .alu_result (memAluResult),
    .sel_data   (sel_data),
    .base_phase (state == BASE),
    .valid      (slot.valid),
    .p_en       (slot.p_en),
    .p_dest     (slot.p_dest),
    .p_data     (slot.p_data),
    .b_dest     (slot.b_dest),
    .b_data     (slot.b_data),
    .cur_en     (cur_en),
    .cur_dest   (cur_dest),
    .cur_data   (cur_data)
  );

  // Same-register collision: the loaded value wins, the base write is dropped.
  always_comb begin
    next_slot.valid  = memValid;
    next_slot.p_en   = memWbEn;
    next_slot.p_dest = memDest;
    next_slot.p_data = sel_data;
    next_slot.b_en   = memBaseWbEn & ~(memWbEn & (memBaseDest == memDest));
    next_slot.b_dest = memBaseDest;
    next_slot.b_data = memBaseValue;
  end

  assign stall = (state == PRIM) & slot.valid & slot.b_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PRIM;
      slot      <= '0;
      last_dest <= '0;
      last_data <= '0;
    end else begin
      state <= stall ? BASE : PRIM;
      if (!stall) slot <= next_slot;
      if (cur_en) begin
        last_dest <= cur_dest;
        last_data <= cur_data;
      end
    end
  end

  // Address and data hold their last written values while no write is enabled.
  assign destWB      = cur_en ? cur_dest : last_dest;
  assign resultWB    = cur_en ? cur_data : last_data;
  assign pcValue     = resultWB;
  assign writeBackEn = cur_en & (cur_dest != PC_REG);
  assign pcLoad      = cur_en & (cur_dest == PC_REG);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: reset, ALU write, dual-write
// load, collision, PC loads and reset during a pending base write.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memValid, memWbEn, memMemRead, memBaseWbEn;
  logic [3:0]  memDest, memBaseDest;
  logic [31:0] memAluResult, memData, memBaseValue;
  logic [3:0]  destWB;
  logic [31:0] resultWB, pcValue;
  logic        writeBackEn, pcLoad, stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk          (clk),
    .rst          (rst),
    .memValid     (memValid),
    .memWbEn      (memWbEn),
    .memMemRead   (memMemRead),
    .memDest      (memDest),
    .memAluResult (memAluResult),
    .memData      (memData),
    .memBaseWbEn  (memBaseWbEn),
    .memBaseDest  (memBaseDest),
    .memBaseValue (memBaseValue),
    .destWB       (destWB),
    .resultWB     (resultWB),
    .writeBackEn  (writeBackEn),
    .pcLoad       (pcLoad),
    .pcValue      (pcValue),
    .stall        (stall)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic rd, input logic [3:0] d,
                       input logic [31:0] alu, input logic [31:0] dat,
                       input logic ben, input logic [3:0] bd, input logic [31:0] bv);
    memValid = v; memWbEn = wb; memMemRead = rd; memDest = d;
    memAluResult = alu; memData = dat;
    memBaseWbEn = ben; memBaseDest = bd; memBaseValue = bv;
  endtask

  task automatic check_port(input string tag, input logic en, input logic pc, input logic st,
                            input logic [3:0] d, input logic [31:0] r);
    check({tag, ".writeBackEn"}, {31'd0, writeBackEn}, {31'd0, en});
    check({tag, ".pcLoad"},      {31'd0, pcLoad},      {31'd0, pc});
    check({tag, ".stall"},       {31'd0, stall},       {31'd0, st});
    check({tag, ".destWB"},      {28'd0, destWB},      {28'd0, d});
    check({tag, ".resultWB"},    resultWB,             r);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    tick();
    check_port("reset", 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    check("reset.pcValue", pcValue, 32'h0);
    rst = 1'b0;
    tick();
    check_port("idle", 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);

    // ALU write R3 <- 0xAA
    drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h0000_00AA, 32'hFFFF_0000, 1'b0, 4'd0, 32'h0);
    tick();
    check_port("alu", 1'b1, 1'b0, 1'b0, 4'd3, 32'h0000_00AA);

    // Load R2 with base writeback R5 <- 0x1000
    drive(1'b1, 1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 4'd5, 32'h0000_1000);
    tick();
    check_port("dual.c1", 1'b1, 1'b0, 1'b1, 4'd2, 32'h1234_5678);
    // Changed during the stalled cycle: ignored now, captured at the end of cycle 2.
    drive(1'b1, 1'b1, 1'b0, 4'd9, 32'h0000_0099, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    check_port("dual.c2", 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_1000);
    tick();
    check_port("after_dual", 1'b1, 1'b0, 1'b0, 4'd9, 32'h0000_0099);

    // Collision: R4 both primary and base; loaded value wins, no stall
    drive(1'b1, 1'b1, 1'b1, 4'd4, 32'h0, 32'hCAFE_BABE, 1'b1, 4'd4, 32'h0000_4444);
    tick();
    check_port("collide", 1'b1, 1'b0, 1'b0, 4'd4, 32'hCAFE_BABE);
    // Bubble: enables low, address/data hold the last write (no hidden BASE cycle)
    drive(1'b0, 1'b1, 1'b1, 4'd7, 32'h0, 32'h0000_0077, 1'b0, 4'd0, 32'h0);
    tick();
    check_port("bubble", 1'b0, 1'b0, 1'b0, 4'd4, 32'hCAFE_BABE);

    // Write to R15 becomes a one-cycle PC load
    drive(1'b1, 1'b1, 1'b0, 4'd15, 32'h0000_0200, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    check_port("pc", 1'b0, 1'b1, 1'b0, 4'd15, 32'h0000_0200);
    check("pc.pcValue", pcValue, 32'h0000_0200);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    check("pc_pulse_end.pcLoad", {31'd0, pcLoad}, 32'd0);

    // Base write to R15: PC load in the BASE cycle
    drive(1'b1, 1'b1, 1'b1, 4'd1, 32'h0, 32'h0000_0011, 1'b1, 4'd15, 32'h0000_0300);
    tick();
    check_port("basepc.c1", 1'b1, 1'b0, 1'b1, 4'd1, 32'h0000_0011);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    check_port("basepc.c2", 1'b0, 1'b1, 1'b0, 4'd15, 32'h0000_0300);
    check("basepc.pcValue", pcValue, 32'h0000_0300);

    // Reset on the edge that would enter BASE: base write R8 never issued
    drive(1'b1, 1'b1, 1'b1, 4'd6, 32'h0, 32'h0000_0066, 1'b1, 4'd8, 32'h0000_0088);
    tick();
    check_port("rstbase.c1", 1'b1, 1'b0, 1'b1, 4'd6, 32'h0000_0066);
    rst = 1'b1;
    tick();
    check_port("rstbase.rst", 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    check("rstbase.pcValue", pcValue, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    check_port("rstbase.after", 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
